// File: rtl/wormhole_output_arbiter.sv
// Per-output-port wormhole arbiter: locks the output link to one input port for a whole
// packet, rotates ownership round-robin between packets, and drives the RTS/DCTS handshake.
module wormhole_output_arbiter #(
    parameter int unsigned MAX_PKT_FLITS = 16,
    parameter int unsigned CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Req_N,
    input  logic             Req_E,
    input  logic             Req_W,
    input  logic             Req_S,
    input  logic             Req_L,
    input  logic             Tail_N,
    input  logic             Tail_E,
    input  logic             Tail_W,
    input  logic             Tail_S,
    input  logic             Tail_L,
    input  logic             DCTS,
    output logic             Grant_N,
    output logic             Grant_E,
    output logic             Grant_W,
    output logic             Grant_S,
    output logic             Grant_L,
    output logic [4:0]       Xbar_sel,
    output logic             RTS,
    output logic             Busy,
    output logic             Err_len
);

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned IDX_W     = 3;
    localparam logic [IDX_W-1:0] IDX_S    = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PORTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       owner_idx;
    logic [CNT_W-1:0]       count;

    logic [NUM_PORTS-1:0]   req;
    logic [NUM_PORTS-1:0]   tail;
    logic [NUM_PORTS-1:0]   grant_vec;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic                   req_owner;
    logic                   tail_owner;
    logic                   xfer;
    logic                   count_last;

    // Bit order matches Xbar_sel: [0]=N [1]=E [2]=W [3]=S [4]=L
    assign req  = {Req_L,  Req_S,  Req_W,  Req_E,  Req_N};
    assign tail = {Tail_L, Tail_S, Tail_W, Tail_E, Tail_N};

    assign req_owner  = |(req  & Xbar_sel);
    assign tail_owner = |(tail & Xbar_sel);
    assign xfer       = (state == BUSY) && RTS && DCTS;
    assign count_last = (count == CNT_W'(MAX_PKT_FLITS - 1));

    assign grant_vec = Xbar_sel & {NUM_PORTS{xfer}};
    assign Grant_N   = grant_vec[0];
    assign Grant_E   = grant_vec[1];
    assign Grant_W   = grant_vec[2];
    assign Grant_S   = grant_vec[3];
    assign Grant_L   = grant_vec[4];

    // Round-robin search starting just after the last-served port; index order is the ring order
    always_comb begin
        logic [IDX_W-1:0] idx;
        win_idx   = ptr;
        win_found = 1'b0;
        idx       = ptr;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            idx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDX_S;
            owner_idx <= '0;
            count     <= '0;
            Xbar_sel  <= '0;
            RTS       <= 1'b0;
            Busy      <= 1'b0;
            Err_len   <= 1'b0;
        end else begin
            Err_len <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= BUSY;
                        owner_idx <= win_idx;
                        Xbar_sel  <= NUM_PORTS'(1) << win_idx;
                        RTS       <= 1'b1;
                        Busy      <= 1'b1;
                        count     <= '0;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        count <= count + CNT_W'(1);
                        RTS   <= 1'b0;
                        // Tail wins over the watchdog; only a watchdog release flags an error
                        if (tail_owner || count_last) begin
                            state    <= IDLE;
                            ptr      <= owner_idx;
                            Xbar_sel <= '0;
                            Busy     <= 1'b0;
                            Err_len  <= !tail_owner;
                        end
                    end else if (!RTS) begin
                        RTS <= req_owner;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed bench for wormhole_output_arbiter; status word is {Busy,RTS,Err_len,Xbar_sel,Grant[4:0]}.
module tb_wormhole_output_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic       dcts;

    logic       Grant_N, Grant_E, Grant_W, Grant_S, Grant_L;
    logic [4:0] Xbar_sel;
    logic       RTS, Busy, Err_len;
    logic [4:0] gnt;
    logic [12:0] st;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wormhole_output_arbiter #(
        .MAX_PKT_FLITS(4),
        .CNT_W        (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Req_N   (req[0]),
        .Req_E   (req[1]),
        .Req_W   (req[2]),
        .Req_S   (req[3]),
        .Req_L   (req[4]),
        .Tail_N  (tail[0]),
        .Tail_E  (tail[1]),
        .Tail_W  (tail[2]),
        .Tail_S  (tail[3]),
        .Tail_L  (tail[4]),
        .DCTS    (dcts),
        .Grant_N (Grant_N),
        .Grant_E (Grant_E),
        .Grant_W (Grant_W),
        .Grant_S (Grant_S),
        .Grant_L (Grant_L),
        .Xbar_sel(Xbar_sel),
        .RTS     (RTS),
        .Busy    (Busy),
        .Err_len (Err_len)
    );

    assign gnt = {Grant_L, Grant_S, Grant_W, Grant_E, Grant_N};
    assign st  = {Busy, RTS, Err_len, Xbar_sel, gnt};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        rst = 1'b1; req = '0; tail = '0; dcts = 1'b0;
        #3;
        exp = '0;
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL reset_async: got %b want %b", st, exp); end
        tick();
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL reset_hold: got %b want %b", st, exp); end
        rst = 1'b0;
        req = 5'b10001;
        tick();
        exp = {1'b1, 1'b1, 1'b0, 5'b10000, 5'b00000};
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL lock_L_over_N: got %b want %b", st, exp); end
        dcts = 1'b1; tail = 5'b10000;
        #1;
        exp = {1'b1, 1'b1, 1'b0, 5'b10000, 5'b10000};
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL grant_L_only: got %b want %b", st, exp); end
        tick();
        req = '0; tail = '0; dcts = 1'b0;
        exp = '0;
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL release_L: got %b want %b", st, exp); end
        tick();
    endtask

    task automatic test_three_flits();
        logic [12:0] exp;
        req = 5'b00010; dcts = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) tail = 5'b00010;
            exp = (c % 2 == 1) ? {1'b1, 1'b1, 1'b0, 5'b00010, 5'b00010}
                               : {1'b1, 1'b0, 1'b0, 5'b00010, 5'b00000};
            n_cmp++;
            if (st !== exp) begin n_err++; $display("FAIL e_flit_cycle%0d: got %b want %b", c, st, exp); end
            tick();
        end
        exp = '0;
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL e_release: got %b want %b", st, exp); end
        req = '0; tail = '0; dcts = 1'b0;
        tick();
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL e_idle_no_err: got %b want %b", st, exp); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        logic [4:0]  own [4];
        own[0] = 5'b00001; own[1] = 5'b00010; own[2] = 5'b00001; own[3] = 5'b00010;
        req = 5'b00011; tail = 5'b00011; dcts = 1'b1;
        for (int p = 0; p < 4; p++) begin
            tick();
            exp = {1'b1, 1'b1, 1'b0, own[p], own[p]};
            n_cmp++;
            if (st !== exp) begin n_err++; $display("FAIL b2b_owner%0d: got %b want %b", p, st, exp); end
            tick();
            exp = '0;
            n_cmp++;
            if (st !== exp) begin n_err++; $display("FAIL b2b_idle%0d: got %b want %b", p, st, exp); end
        end
        req = '0; tail = '0; dcts = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [12:0] exp;
        req = 5'b00100; dcts = 1'b0;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) req = '0;
            exp = {1'b1, 1'b1, 1'b0, 5'b00100, 5'b00000};
            n_cmp++;
            if (st !== exp) begin n_err++; $display("FAIL stall_cycle%0d: got %b want %b", c, st, exp); end
            tick();
        end
        dcts = 1'b1; tail = 5'b00100;
        #1;
        exp = {1'b1, 1'b1, 1'b0, 5'b00100, 5'b00100};
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL stall_grant_W: got %b want %b", st, exp); end
        tick();
        exp = '0;
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL stall_release: got %b want %b", st, exp); end
        tail = '0; dcts = 1'b0;
    endtask

    task automatic test_watchdog();
        logic [12:0] exp;
        req = 5'b01000; dcts = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            exp = (c % 2 == 1) ? {1'b1, 1'b1, 1'b0, 5'b01000, 5'b01000}
                               : {1'b1, 1'b0, 1'b0, 5'b01000, 5'b00000};
            n_cmp++;
            if (st !== exp) begin n_err++; $display("FAIL wd_cycle%0d: got %b want %b", c, st, exp); end
            tick();
        end
        exp = {1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000};
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL wd_err_pulse: got %b want %b", st, exp); end
        req = 5'b01010;
        tick();
        exp = {1'b1, 1'b1, 1'b0, 5'b00010, 5'b00010};
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL wd_next_not_S: got %b want %b", st, exp); end
        tail = 5'b00010;
        tick();
        exp = '0;
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL wd_tail_no_err: got %b want %b", st, exp); end
        req = '0; tail = '0; dcts = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        logic [12:0] exp;
        req = 5'b00001; dcts = 1'b0;
        tick();
        exp = {1'b1, 1'b1, 1'b0, 5'b00001, 5'b00000};
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL rst_lock_N: got %b want %b", st, exp); end
        dcts = 1'b1;
        #1;
        exp = {1'b1, 1'b1, 1'b0, 5'b00001, 5'b00001};
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL rst_grant_N: got %b want %b", st, exp); end
        #1;
        rst = 1'b1;
        #1;
        exp = '0;
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL rst_async_clear: got %b want %b", st, exp); end
        req = 5'b10011;
        tick();
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL rst_held: got %b want %b", st, exp); end
        rst = 1'b0;
        tick();
        exp = {1'b1, 1'b1, 1'b0, 5'b10000, 5'b10000};
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL rst_L_first: got %b want %b", st, exp); end
        tail = 5'b10000;
        tick();
        exp = '0;
        n_cmp++;
        if (st !== exp) begin n_err++; $display("FAIL rst_L_release: got %b want %b", st, exp); end
        req = '0; tail = '0; dcts = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_three_flits();
        test_back_to_back();
        test_stall();
        test_watchdog();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
